// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the riscv32i pipeline stage registers:
// bubble instruction encoding, default-width IF/ID payload and its bubble value.
package riscv_pipe_pkg;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN_DEF = 32;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
    logic                fault;
  } if_id_payload_t;

  localparam if_id_payload_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, fault: 1'b0};

endpackage

// File: rtl/pipe_skid_entry.sv
// Single payload register with valid flag. clear has priority over load and
// returns the entry to its bubble value.
module pipe_skid_entry #(
  parameter int unsigned   W      = 65,
  parameter logic [W-1:0]  BUBBLE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Payload and valid update: clear wins, otherwise load captures d.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= BUBBLE;
      valid <= 1'b0;
    end else if (clear) begin
      q     <= BUBBLE;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with valid/ready handshake, flush and a saturating
// stall-cycle counter. Define IF_ID_SKID_EN to add a second (skid) entry that
// registers in_ready and removes the out_ready->in_ready combinational path.
module if_id_pipe_reg
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ILEN      = 32,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = riscv_pipe_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [ILEN-1:0]  in_instr,
  input  logic             in_fault,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [ILEN-1:0]  out_instr,
  output logic             out_fault,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned   PW     = XLEN + ILEN + 1;
  localparam logic [ILEN-1:0] NOP_L = ILEN'(NOP_INSTR);
  localparam logic [PW-1:0] BUBBLE = {{XLEN{1'b0}}, NOP_L, 1'b0};

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic          main_load;
  logic          main_clear;
  logic          in_xfer;
  logic          out_xfer;

  assign in_payload = {in_pc, in_instr, in_fault};
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;
  assign {out_pc, out_instr, out_fault} = main_q;

  pipe_skid_entry #(
    .W      (PW),
    .BUBBLE (BUBBLE)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (main_q),
    .valid (out_valid)
  );

`ifdef IF_ID_SKID_EN
  logic [PW-1:0] skid_q;
  logic          skid_valid;
  logic          skid_load;
  logic          skid_clear;

  // in_ready is the skid flag (a flop), held low during reset.
  assign in_ready = reset && !skid_valid;

  // Skid is only filled while main is full and stalled, so whenever it holds
  // data it feeds main ahead of any newer fetch (in_ready is low then).
  always_comb begin
    main_d     = skid_valid ? skid_q : in_payload;
    main_load  = !flush_i && (skid_valid ? out_xfer
                                         : (in_xfer && (!out_valid || out_ready)));
    skid_load  = !flush_i && !skid_valid && in_xfer && out_valid && !out_ready;
    skid_clear = flush_i || (skid_valid && out_xfer);
    main_clear = flush_i || (out_xfer && !main_load);
  end

  pipe_skid_entry #(
    .W      (PW),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_payload),
    .q     (skid_q),
    .valid (skid_valid)
  );
`else
  // Single entry: accept when empty or when the held entry leaves this cycle.
  assign in_ready = reset && (!out_valid || out_ready);

  // Load on input transfer; return to bubble on drain or flush.
  always_comb begin
    main_d     = in_payload;
    main_load  = !flush_i && in_xfer;
    main_clear = flush_i || (out_xfer && !in_xfer);
  end
`endif

  // Saturating count of cycles where ID back-pressures a valid entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: directed vectors push expected entries,
// a negedge monitor pops and compares on every output transfer.
module tb_if_id_pipe_reg;
  import riscv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_fault = 1'b0;

  logic        in_ready, out_valid, out_fault;
  logic [31:0] out_pc, out_instr;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_out_fault;
  logic [31:0] s_out_pc, s_out_instr;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;
  if_id_payload_t exp_q[$];

  if_id_pipe_reg #(.XLEN(32), .ILEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_fault(in_fault),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault),
    .stall_cnt(stall_cnt)
  );

  if_id_pipe_reg #(.XLEN(32), .ILEN(32), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_fault(in_fault),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .out_instr(s_out_instr), .out_fault(s_out_fault),
    .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic f);
    if_id_payload_t e;
    e.pc = pc;
    e.instr = instr;
    e.fault = f;
    exp_q.push_back(e);
  endtask

  // Present one fetch and hold it until the stage accepts it (bounded).
  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic f);
    bit acc;
    acc = 1'b0;
    in_pc = pc;
    in_instr = instr;
    in_fault = f;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: pc %0h not accepted, expected accept within 50 cycles", pc);
    end
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  initial begin
    if_id_payload_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready && !flush_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got pc=%0h instr=%0h, expected no entry", out_pc, out_instr);
        end else begin
          e = exp_q.pop_front();
          if (out_pc !== e.pc || out_instr !== e.instr || out_fault !== e.fault) begin
            errors++;
            $display("FAIL out_entry: got pc=%0h instr=%0h fault=%0b, expected pc=%0h instr=%0h fault=%0b",
                     out_pc, out_instr, out_fault, e.pc, e.instr, e.fault);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    check("rst_out_fault", out_fault, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b1;
    step();

    // Full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(32'(4 * i), 32'h0010_0093 + 32'(i), 1'b0);
      drive(32'(4 * i), 32'h0010_0093 + 32'(i), 1'b0);
      check("thru_valid", out_valid, 1);
      check("thru_pc", out_pc, 64'(4 * i));
    end
    step();
    step();
    check("thru_drained", out_valid, 0);
    check("thru_stall_cnt", stall_cnt, 0);
    check("thru_queue_empty", exp_q.size(), 0);

    // Back-pressure: 0x20 held 5 cycles, 0x24 waiting behind it
    out_ready = 1'b0;
    push(32'h20, 32'h0020_0113, 1'b0);
    drive(32'h20, 32'h0020_0113, 1'b0);
    push(32'h24, 32'h0030_0193, 1'b0);
    fork
      drive(32'h24, 32'h0030_0193, 1'b0);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_valid", out_valid, 1);
          check("bp_pc", out_pc, 32'h20);
          check("bp_instr", out_instr, 32'h0020_0113);
`ifdef IF_ID_SKID_EN
          check("bp_in_ready", in_ready, (i == 0) ? 1 : 0);
`else
          check("bp_in_ready", in_ready, 0);
`endif
        end
        step();
        check("bp_stall_cnt", stall_cnt, 5);
        out_ready = 1'b1;
      end
    join
    step();
    step();
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_drained", out_valid, 0);

    // Flush collision: held 0x30 leaves and 0x40 arrives under flush
    out_ready = 1'b0;
    drive(32'h30, 32'h0040_0213, 1'b0);
    flush_i = 1'b1;
    in_pc = 32'h40;
    in_instr = 32'h0050_0293;
    in_fault = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    flush_i = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_instr", out_instr, 32'h0000_0013);
    check("fl_pc", out_pc, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_stall_cnt", stall_cnt, 5);
    step();
    step();
    check("fl_still_empty", out_valid, 0);

    // Fault propagation
    push(32'h7c, 32'h0060_0313, 1'b0);
    drive(32'h7c, 32'h0060_0313, 1'b0);
    push(32'h80, 32'h0070_0393, 1'b1);
    drive(32'h80, 32'h0070_0393, 1'b1);
    check("fault_set", out_fault, 1);
    push(32'h84, 32'h0080_0413, 1'b0);
    drive(32'h84, 32'h0080_0413, 1'b0);
    check("fault_clear", out_fault, 0);
    step();
    step();
    check("fault_queue_empty", exp_q.size(), 0);

    // Reset mid-stall
    out_ready = 1'b0;
    drive(32'h100, 32'h0090_0493, 1'b0);
    step();
    step();
    check("mid_pc_held", out_pc, 32'h100);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_pc", out_pc, 0);
    check("mid_rst_instr", out_instr, 32'h0000_0013);
    check("mid_rst_fault", out_fault, 0);
    check("mid_rst_stall", stall_cnt, 0);
    check("mid_rst_in_ready", in_ready, 0);
    step();
    reset = 1'b1;
    step();

    // Saturation: 20 stall cycles
    push(32'h200, 32'h00a0_0513, 1'b0);
    drive(32'h200, 32'h00a0_0513, 1'b0);
    repeat (20) step();
    check("sat_cnt16", stall_cnt, 20);
    check("sat_cnt4", s_stall_cnt, 15);
    out_ready = 1'b1;
    step();
    step();
    check("sat_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Parametrised fetch-to-decode pipeline register for the riscv32i core. Carries PC, instruction and a fetch-fault flag from IF to ID.
- Uses a valid/ready handshake, supports flush, and inserts a NOP bubble whenever it is empty.
- Exports a saturating stall-cycle counter for performance monitoring.
- Replaces the fixed 32-bit, enable-only IF/IM stage register with a back-pressure-aware, width-generic stage.

Parameters:
- XLEN, 32, PC width in bits.
- ILEN, 32, instruction width in bits.
- CNT_W, 16, stall counter width.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0), truncated or zero-extended to ILEN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush_i  in  1  kill all held and incoming entries (branch/jump redirect)
- in_valid  in  1  IF presents a valid fetch
- in_ready  out  1  stage accepts the fetch this cycle
- in_pc  in  XLEN  fetch PC
- in_instr  in  ILEN  fetched instruction
- in_fault  in  1  fetch access fault
- out_valid  out  1  ID-side entry valid
- out_ready  in  1  ID accepts the entry
- out_pc  out  XLEN  held PC; 0 when empty
- out_instr  out  ILEN  held instruction; NOP_INSTR when empty
- out_fault  out  1  held fault flag; 0 when empty
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_fault=0, stall_cnt=0.
  - Skid entry (if built) is cleared.
  - in_ready=0 while reset is asserted.
  - Release is synchronous to clk.
- Handshakes:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Base mode (no skid buffer), one register entry:
  - in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
  - Transfer in: the entry loads in_pc/in_instr/in_fault and sets out_valid=1 on the next edge. Latency is 1 cycle.
  - Output transfer without input transfer: the entry returns to bubble values and out_valid=0.
  - Simultaneous input and output transfer: the entry is replaced. Full throughput, no bubble.
  - Stall (out_valid && !out_ready): all out_* hold stable. in_valid is ignored because in_ready=0.
- Flush:
  - flush_i=1 at an edge sets out_valid=0 and loads bubble values.
  - An input transfer in the same cycle is discarded.
  - Flush overrides every other event, including a simultaneous output transfer.
  - in_ready is unaffected by flush_i.
- in_valid deasserted: the entry drains normally and out_valid falls after the output transfer.
- stall_cnt:
  - Increments by 1 on every edge where out_valid && !out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Unaffected by flush; cleared only by reset.
- Upstream is allowed to change in_* while in_ready=0. The stage never samples in_* then.

Optional Feature:
- Macro: IF_ID_SKID_EN.
- Defined: a second skid entry is instantiated.
  - in_ready becomes a register equal to "skid empty". There is no combinational out_ready-to-in_ready path.
  - Input transfer while main is full and out_ready=0: data goes into skid, and in_ready falls on the next edge.
  - When main drains, skid moves to main on that edge and in_ready rises.
  - Order is preserved: skid data always leaves before any newer input.
  - Flush clears both entries and sets in_ready=1.
  - Maximum occupancy is 2.
- Undefined: base single-entry behaviour, combinational in_ready.
- Both builds give identical transfer order and per-entry latency of 1 cycle when unstalled.

Decomposition:
- Package riscv_pipe_pkg holds:
  - the NOP_INSTR constant;
  - the typedef if_id_payload_t (struct: pc, instr, fault);
  - a bubble constant of that type.
- Natural sub-module: pipe_skid_entry, a single payload register with load/clear/valid. It is instantiated once for main and, under IF_ID_SKID_EN, once for skid.

Test Plan:
- Reset mid-stall: entry pc=0x100 held with out_ready=0; pull reset low asynchronously. Outputs go to 0/NOP_INSTR/0 immediately and stall_cnt=0.
- Full throughput: in_valid=1, out_ready=1, PCs 0x0,0x4,0x8. out_pc sequence 0x0,0x4,0x8 one cycle later, no bubbles, stall_cnt=0.
- Back-pressure: out_ready=0 for 5 cycles with entry 0x20. out_* stable, in_ready=0 (base) or one extra entry absorbed (skid), stall_cnt=5, no loss or reorder after release.
- Flush collision: flush_i=1 with an input transfer of pc=0x40 and an output transfer in the same cycle. Next cycle out_valid=0, out_instr=0x00000013; 0x40 never appears.
- Fault propagation: in_fault=1 at pc=0x80. out_fault=1 alongside out_pc=0x80 for exactly that entry.
- Saturation: CNT_W=4, stall 20 cycles. stall_cnt stops at 15.
